// File: rtl/lbm_cell_sweeper.sv
`default_nettype none
// ============================================================================
// Module : lbm_cell_sweeper
// Walks every lattice cell in row-major order: read from the distribution
// BRAM, hand the nine densities to the collision unit, write the result back.
// Rev    : 1.0
// ============================================================================
module lbm_cell_sweeper #(
  parameter int GRID_W       = 64,
  parameter int GRID_H       = 48,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_W       = $clog2(GRID_W*GRID_H)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              abort_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [8:0][7:0]   bram_rd_data_in,
  output logic              bram_we_out,
  output logic [8:0][7:0]   bram_wr_data_out,
  output logic [8:0][7:0]   coll_data_out,
  output logic              coll_valid_out,
  input  logic [8:0][7:0]   coll_data_in,
  input  logic              coll_done_in,
  output logic              busy_out,
  output logic              sweep_done_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_COLL = 3'd4,
    S_WRITE     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W*GRID_H-1);
  localparam logic [1:0]        LAT_INIT  = 2'(BRAM_LATENCY-1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lat_q, lat_d;
  logic [8:0][7:0]   cell_q, cell_d;
  logic [8:0][7:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lat_d    = lat_q;
    cell_d   = cell_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_in && !abort_in) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_q == 2'd0) begin
          cell_d  = bram_rd_data_in;
          state_d = S_ISSUE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_ISSUE: state_d = S_WAIT_COLL;
      S_WAIT_COLL: begin
        if (coll_done_in) begin
          result_d = coll_data_in;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including the address step out of WRITE.
    if (abort_in && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
    end
  end

  always_comb begin
    valid_d = (state_d == S_ISSUE);
    we_d    = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lat_q    <= 2'd0;
      cell_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      cell_q   <= cell_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // An abort arriving in the WRITE (or DONE) cycle itself must still cancel it.
  assign bram_we_out      = we_q & ~abort_in;
  assign sweep_done_out   = done_q & ~abort_in;
  assign bram_addr_out    = addr_q;
  assign bram_wr_data_out = result_q;
  assign coll_data_out    = cell_q;
  assign coll_valid_out   = valid_q;
  assign busy_out         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lbm_cell_sweeper.sv
`default_nettype none
// Directed bench for lbm_cell_sweeper on a 4x2 lattice: instance 0 uses a
// 2-cycle BRAM, instance 1 a 1-cycle BRAM; both share clock and reset.
module tb_lbm_cell_sweeper;

  localparam int N = 8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                  rst_n;
  logic [1:0]            start, abort, we, cv, cdone, busy, sdone;
  logic [1:0][2:0]       baddr;
  logic [1:0][8:0][7:0]  rd, wr, cdo, cdi;

  logic [71:0] mem [2][N];
  logic [2:0]  pipe [2][2];
  logic [71:0] res [2];
  logic [1:0]  sched, pend, early;
  int          cnt [2], vcount [2], wcount [2], ord_err [2], we_cv [2];
  int          dly [2][N];
  int          n_cmp = 0, n_err = 0;

  lbm_cell_sweeper #(.GRID_W(4), .GRID_H(2), .BRAM_LATENCY(2)) dut_l2 (
    .clk_in(clk_in), .rst_in(rst_n), .start_in(start[0]), .abort_in(abort[0]),
    .bram_addr_out(baddr[0]), .bram_rd_data_in(rd[0]), .bram_we_out(we[0]),
    .bram_wr_data_out(wr[0]), .coll_data_out(cdo[0]), .coll_valid_out(cv[0]),
    .coll_data_in(cdi[0]), .coll_done_in(cdone[0]), .busy_out(busy[0]),
    .sweep_done_out(sdone[0])
  );

  lbm_cell_sweeper #(.GRID_W(4), .GRID_H(2), .BRAM_LATENCY(1)) dut_l1 (
    .clk_in(clk_in), .rst_in(rst_n), .start_in(start[1]), .abort_in(abort[1]),
    .bram_addr_out(baddr[1]), .bram_rd_data_in(rd[1]), .bram_we_out(we[1]),
    .bram_wr_data_out(wr[1]), .coll_data_out(cdo[1]), .coll_valid_out(cv[1]),
    .coll_data_in(cdi[1]), .coll_done_in(cdone[1]), .busy_out(busy[1]),
    .sweep_done_out(sdone[1])
  );

  function automatic logic [71:0] pat(input int k, input int i);
    logic [71:0] r;
    for (int b = 0; b < 9; b++) r[8*b +: 8] = 8'(i*16 + b*3 + k);
    return r;
  endfunction

  function automatic logic [71:0] plus1(input logic [71:0] v);
    logic [71:0] r;
    for (int b = 0; b < 9; b++) r[8*b +: 8] = v[8*b +: 8] + 8'd1;
    return r;
  endfunction

  // BRAM read port and collision unit responses.
  always_comb begin
    rd    = '0;
    cdone = '0;
    cdi   = '0;
    rd[0] = mem[0][pipe[0][1]];
    rd[1] = mem[1][pipe[1][0]];
    for (int k = 0; k < 2; k++) begin
      cdone[k] = (early[k] & cv[k]) | sched[k];
      cdi[k]   = (early[k] & cv[k]) ? {9{8'hEE}} : res[k];
    end
  end

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        sched[k] <= 1'b0; pend[k] <= 1'b0; cnt[k] <= 0; res[k] <= '0;
        vcount[k] <= 0; wcount[k] <= 0; ord_err[k] <= 0; we_cv[k] <= 0;
        pipe[k][0] <= '0; pipe[k][1] <= '0;
        for (int i = 0; i < N; i++) mem[k][i] <= pat(k, i);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        pipe[k][0] <= baddr[k];
        pipe[k][1] <= pipe[k][0];
        sched[k]   <= 1'b0;
        if (cv[k]) begin
          vcount[k] <= vcount[k] + 1;
          res[k]    <= plus1(cdo[k]);
          if (dly[k][vcount[k] % N] <= 1) sched[k] <= 1'b1;
          else begin
            pend[k] <= 1'b1;
            cnt[k]  <= dly[k][vcount[k] % N] - 1;
          end
        end else if (pend[k]) begin
          if (cnt[k] == 1) begin
            sched[k] <= 1'b1;
            pend[k]  <= 1'b0;
          end else cnt[k] <= cnt[k] - 1;
        end
        if (we[k]) begin
          mem[k][baddr[k]] <= wr[k];
          if (int'(baddr[k]) != wcount[k]) ord_err[k] <= ord_err[k] + 1;
          if (cv[k]) we_cv[k] <= we_cv[k] + 1;
          wcount[k] <= wcount[k] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    start = '0;
    abort = '0;
    early = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // cyc is the cycle index relative to the cycle in which start_in was high.
  task automatic wait_done(input int k, input int budget, input int cyc0, output int cyc);
    cyc = cyc0;
    while (!sdone[k] && cyc < budget) begin
      tick();
      cyc++;
    end
    check($sformatf("done_seen%0d", k), 72'(sdone[k]), 72'd1);
  endtask

  task automatic sweep_checks(input int k, input string tag);
    check({tag, "_writes"}, 72'(wcount[k]), 72'd8);
    check({tag, "_valids"}, 72'(vcount[k]), 72'd8);
    check({tag, "_order"}, 72'(ord_err[k]), 72'd0);
    check({tag, "_we_in_issue"}, 72'(we_cv[k]), 72'd0);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_mem%0d", tag, i), mem[k][i], plus1(pat(k, i)));
  endtask

  task automatic set_dly(input int k, input int v);
    for (int i = 0; i < N; i++) dly[k][i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, n, ndone;
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    early = '0;
    set_dly(0, 1);
    set_dly(1, 1);
    #12;
    check("rst_addr", 72'(baddr[0]), 72'd0);
    check("rst_we", 72'(we[0]), 72'd0);
    check("rst_wr", wr[0], 72'd0);
    check("rst_coll", cdo[0], 72'd0);
    check("rst_valid", 72'(cv[0]), 72'd0);
    check("rst_busy", 72'(busy[0]), 72'd0);
    check("rst_done", 72'(sdone[0]), 72'd0);
    rst_n = 1'b1;
    tick();

    // start together with abort in IDLE is ignored
    start[0] = 1'b1; abort[0] = 1'b1;
    tick();
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort_idle", 72'(busy[0]), 72'd0);
    tick();
    check("start_abort_idle2", 72'(busy[0]), 72'd0);

    // plain sweep, 2-cycle BRAM, collision answers one cycle after valid
    do_reset();
    pulse_start(0);
    check("busy_rise", 72'(busy[0]), 72'd1);
    wait_done(0, 200, 1, cyc);
    check("sweep_cycles", 72'(cyc), 72'd49);
    tick();
    check("done_one_cycle", 72'(sdone[0]), 72'd0);
    check("busy_fall", 72'(busy[0]), 72'd0);
    check("cell0_literal", mem[0][0], 72'h19_16_13_10_0D_0A_07_04_01);
    sweep_checks(0, "basic");

    // collision latency varying per cell
    do_reset();
    dly[0] = '{1, 7, 32, 1, 7, 32, 1, 7};
    pulse_start(0);
    wait_done(0, 400, 1, cyc);
    check("var_cycles", 72'(cyc), 72'd129);
    tick();
    sweep_checks(0, "varlat");

    // done also pulsed in ISSUE with junk data, real answer 3 cycles later
    do_reset();
    set_dly(0, 3);
    early[0] = 1'b1;
    pulse_start(0);
    wait_done(0, 200, 1, cyc);
    check("early_cycles", 72'(cyc), 72'd65);
    tick();
    early[0] = 1'b0;
    sweep_checks(0, "early");

    // abort in the WRITE cycle of cell 3
    do_reset();
    set_dly(0, 1);
    pulse_start(0);
    n = 0;
    while (!(we[0] && baddr[0] == 3'd3) && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach_write3", 72'(we[0] && baddr[0] == 3'd3), 72'd1);
    abort[0] = 1'b1;
    #1;
    check("abort_we", 72'(we[0]), 72'd0);
    tick();
    abort[0] = 1'b0;
    check("abort_busy", 72'(busy[0]), 72'd0);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (sdone[0]) ndone++;
      tick();
    end
    check("abort_no_done", 72'(ndone), 72'd0);
    check("abort_writes", 72'(wcount[0]), 72'd3);
    for (int i = 0; i < N; i++)
      check($sformatf("abort_mem%0d", i), mem[0][i], (i < 3) ? plus1(pat(0, i)) : pat(0, i));

    // asynchronous reset while waiting on the collision for cell 5
    do_reset();
    dly[0] = '{1, 1, 1, 1, 1, 20, 1, 1};
    pulse_start(0);
    n = 0;
    while (vcount[0] < 6 && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("pre_rst_addr", 72'(baddr[0]), 72'd5);
    check("pre_rst_busy", 72'(busy[0]), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 72'(baddr[0]), 72'd0);
    check("mid_rst_wr", wr[0], 72'd0);
    check("mid_rst_coll", cdo[0], 72'd0);
    check("mid_rst_valid", 72'(cv[0]), 72'd0);
    check("mid_rst_busy", 72'(busy[0]), 72'd0);
    check("mid_rst_we", 72'(we[0]), 72'd0);
    check("mid_rst_done", 72'(sdone[0]), 72'd0);
    rst_n = 1'b1;
    tick();
    set_dly(0, 1);
    pulse_start(0);
    wait_done(0, 200, 1, cyc);
    check("post_rst_cycles", 72'(cyc), 72'd49);
    tick();
    sweep_checks(0, "postrst");

    // 1-cycle BRAM, extra start pulses while busy
    do_reset();
    set_dly(1, 1);
    pulse_start(1);
    repeat (10) tick();
    pulse_start(1);
    check("l1_busy_mid", 72'(busy[1]), 72'd1);
    repeat (7) tick();
    pulse_start(1);
    wait_done(1, 200, 20, cyc);
    check("l1_cycles", 72'(cyc), 72'd41);
    tick();
    check("l1_busy_fall", 72'(busy[1]), 72'd0);
    sweep_checks(1, "l1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
